// File: rtl/input_button_ctrl.sv
// Button event scheduler: per-button hold-timer FSMs feed pending slots, which a round-robin arbiter drains into a shared event FIFO.
// Optional macro INPUT_BUTTON_CTRL_REPEAT_EN enables periodic REPEAT events while a button stays held past LONG.
module input_button_ctrl #(
    parameter int N            = 5,
    parameter int LONG_TICKS   = 100_000_000,
    parameter int REPEAT_TICKS = 20_000_000,
    parameter int DEPTH        = 8,
    localparam int IDX_W       = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     btn_ondn,
    input  logic [N-1:0]     btn_onup,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [1:0]       ev_type,
    output logic [IDX_W-1:0] ev_idx,
    output logic [7:0]       drop_cnt
);

    localparam int MAXT  = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int TW    = $clog2(MAXT + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_LONG    = 2'd1;
    localparam logic [1:0] EV_REPEAT  = 2'd2;
    localparam logic [1:0] EV_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_REPEAT
    } state_e;

    state_e            state_q [N];
    state_e            state_d [N];
    logic [TW-1:0]     timer_q [N];
    logic [TW-1:0]     timer_d [N];
    logic [N-1:0]      gen_v;
    logic [1:0]        gen_t   [N];

    logic [N-1:0]      slot_v_q;
    logic [N-1:0]      slot_v_d;
    logic [1:0]        slot_t_q [N];
    logic [1:0]        slot_t_d [N];

    logic              grant_v;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  rr_q;
    logic [IDX_W-1:0]  rr_d;
    logic [7:0]        drop_q;
    logic [7:0]        drop_d;

    logic [1:0]        mem_t_q [DEPTH];
    logic [IDX_W-1:0]  mem_i_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              pop;

    // Hold-timer FSMs: a release always wins over timer expiry in the same cycle.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            gen_v[i]   = 1'b0;
            gen_t[i]   = EV_PRESS;
            case (state_q[i])
                S_IDLE: begin
                    if (btn_ondn[i]) begin
                        state_d[i] = S_HELD;
                        timer_d[i] = '0;
                        gen_v[i]   = 1'b1;
                        gen_t[i]   = EV_PRESS;
                    end
                end
                S_HELD: begin
                    if (btn_onup[i]) begin
                        state_d[i] = S_IDLE;
                        timer_d[i] = '0;
                        gen_v[i]   = 1'b1;
                        gen_t[i]   = EV_RELEASE;
                    end else if (timer_q[i] == TW'(LONG_TICKS - 1)) begin
                        state_d[i] = S_REPEAT;
                        timer_d[i] = '0;
                        gen_v[i]   = 1'b1;
                        gen_t[i]   = EV_LONG;
                    end else begin
                        timer_d[i] = timer_q[i] + TW'(1);
                    end
                end
                S_REPEAT: begin
                    if (btn_onup[i]) begin
                        state_d[i] = S_IDLE;
                        timer_d[i] = '0;
                        gen_v[i]   = 1'b1;
                        gen_t[i]   = EV_RELEASE;
                    end else begin
`ifdef INPUT_BUTTON_CTRL_REPEAT_EN
                        if (timer_q[i] == TW'(REPEAT_TICKS - 1)) begin
                            timer_d[i] = '0;
                            gen_v[i]   = 1'b1;
                            gen_t[i]   = EV_REPEAT;
                        end else begin
                            timer_d[i] = timer_q[i] + TW'(1);
                        end
`else
                        timer_d[i] = '0;
`endif
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    timer_d[i] = '0;
                end
            endcase
        end
    end

    // Round-robin grant starting at rr; the full check deliberately ignores a same-cycle pop.
    always_comb begin
        int j;
        j         = 0;
        grant_v   = 1'b0;
        grant_idx = '0;
        if (count_q < CNT_W'(DEPTH)) begin
            for (int k = 0; k < N; k++) begin
                j = (int'(rr_q) + k) % N;
                if (!grant_v && slot_v_q[j]) begin
                    grant_v   = 1'b1;
                    grant_idx = IDX_W'(j);
                end
            end
        end
        rr_d = rr_q;
        if (grant_v) begin
            rr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Pending slots: a granted slot absorbs a fresh event for free; otherwise a busy slot only yields to RELEASE.
    always_comb begin
        int ndrop;
        ndrop = 0;
        for (int i = 0; i < N; i++) begin
            slot_v_d[i] = slot_v_q[i];
            slot_t_d[i] = slot_t_q[i];
            if (grant_v && (grant_idx == IDX_W'(i))) begin
                slot_v_d[i] = gen_v[i];
                if (gen_v[i]) begin
                    slot_t_d[i] = gen_t[i];
                end
            end else if (gen_v[i]) begin
                if (!slot_v_q[i]) begin
                    slot_v_d[i] = 1'b1;
                    slot_t_d[i] = gen_t[i];
                end else begin
                    ndrop = ndrop + 1;
                    if (gen_t[i] == EV_RELEASE) begin
                        slot_t_d[i] = EV_RELEASE;
                    end
                end
            end
        end
        drop_d = ((int'(drop_q) + ndrop) > 255) ? 8'd255 : drop_q + 8'(ndrop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                state_q[i]  <= S_IDLE;
                timer_q[i]  <= '0;
                slot_t_q[i] <= EV_PRESS;
            end
            slot_v_q <= '0;
            rr_q     <= '0;
            drop_q   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i]  <= state_d[i];
                timer_q[i]  <= timer_d[i];
                slot_t_q[i] <= slot_t_d[i];
            end
            slot_v_q <= slot_v_d;
            rr_q     <= rr_d;
            drop_q   <= drop_d;
        end
    end

    assign pop = ev_valid & ev_ready;

    // Event FIFO: the head registers are cleared on reset so the outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                mem_t_q[d] <= '0;
                mem_i_q[d] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (grant_v) begin
                mem_t_q[wptr_q] <= slot_t_q[grant_idx];
                mem_i_q[wptr_q] <= grant_idx;
                wptr_q          <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (grant_v && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!grant_v && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign ev_valid = (count_q != '0);
    assign ev_type  = mem_t_q[rptr_q];
    assign ev_idx   = mem_i_q[rptr_q];
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_input_button_ctrl.sv
// Self-checking bench for input_button_ctrl with N=4, LONG_TICKS=10, REPEAT_TICKS=4, DEPTH=4.
// Cycle k of a table row: inputs are driven during cycle k and the registered outputs of cycle k are compared.
module tb_input_button_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] btnOndn;
    logic [3:0] btnOnup;
    logic       evValid;
    logic       evReady;
    logic [1:0] evType;
    logic [1:0] evIdx;
    logic [7:0] dropCnt;

    int compared;
    int mismatched;

    typedef struct {
        logic [3:0] ondn;
        logic [3:0] onup;
        logic       ready;
        logic       expValid;
        logic [1:0] expType;
        logic [1:0] expIdx;
        logic [7:0] expDrop;
    } vec_t;

    vec_t tbl[$];

    input_button_ctrl #(
        .N(4),
        .LONG_TICKS(10),
        .REPEAT_TICKS(4),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_ondn(btnOndn),
        .btn_onup(btnOnup),
        .ev_valid(evValid),
        .ev_ready(evReady),
        .ev_type(evType),
        .ev_idx(evIdx),
        .drop_cnt(dropCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (actual timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] dn, input logic [3:0] up, input logic rdy);
        btnOndn = dn;
        btnOnup = up;
        evReady = rdy;
    endtask

    function automatic void addVec(input logic [3:0] dn, input logic [3:0] up, input logic rdy,
                                   input logic v, input logic [1:0] t, input logic [1:0] i,
                                   input logic [7:0] d);
        vec_t r;
        r.ondn = dn; r.onup = up; r.ready = rdy;
        r.expValid = v; r.expType = t; r.expIdx = i; r.expDrop = d;
        tbl.push_back(r);
    endfunction

    function automatic void addIdle(input int n, input logic rdy, input logic [7:0] d);
        for (int k = 0; k < n; k++) addVec(4'b0, 4'b0, rdy, 1'b0, 2'd0, 2'd0, d);
    endfunction

    task automatic doReset(input string tag);
        rst = 1'b1;
        applyStimulus(4'b0, 4'b0, 1'b1);
        step();
        step();
        checkOutput({tag, " reset valid"}, 32'(evValid), 32'd0);
        checkOutput({tag, " reset type"}, 32'(evType), 32'd0);
        checkOutput({tag, " reset idx"}, 32'(evIdx), 32'd0);
        checkOutput({tag, " reset drop"}, 32'(dropCnt), 32'd0);
        rst = 1'b0;
    endtask

    task automatic runTable(input string tag);
        for (int k = 0; k < tbl.size(); k++) begin
            applyStimulus(tbl[k].ondn, tbl[k].onup, tbl[k].ready);
            checkOutput($sformatf("%s c%0d valid", tag, k), 32'(evValid), 32'(tbl[k].expValid));
            if (tbl[k].expValid) begin
                checkOutput($sformatf("%s c%0d type", tag, k), 32'(evType), 32'(tbl[k].expType));
                checkOutput($sformatf("%s c%0d idx", tag, k), 32'(evIdx), 32'(tbl[k].expIdx));
            end
            checkOutput($sformatf("%s c%0d drop", tag, k), 32'(dropCnt), 32'(tbl[k].expDrop));
            step();
        end
        tbl.delete();
    endtask

    // Hand-derived event schedule for a button pressed at cycle 0 and released at cycle 30.
    task automatic expectLong(input int c, output logic v, output logic [1:0] t);
        int g;
        g = c - 2;
        v = 1'b0;
        t = 2'd0;
        if (g == 0) begin v = 1'b1; t = 2'd0; end
        if (g == 10) begin v = 1'b1; t = 2'd1; end
        if (g == 30) begin v = 1'b1; t = 2'd3; end
`ifdef INPUT_BUTTON_CTRL_REPEAT_EN
        if (g == 14 || g == 18 || g == 22 || g == 26) begin v = 1'b1; t = 2'd2; end
`endif
    endtask

    initial begin
        logic       v;
        logic [1:0] t;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        applyStimulus(4'b0, 4'b0, 1'b1);

        // Short press on button 2: PRESS at 7, RELEASE at 10.
        doReset("t1");
        addIdle(5, 1'b1, 8'd0);
        addVec(4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0);
        addIdle(1, 1'b1, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd2, 8'd0);
        addVec(4'b0000, 4'b0100, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0);
        addIdle(1, 1'b1, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd2, 8'd0);
        addIdle(2, 1'b1, 8'd0);
        runTable("t1");

        // Long hold on button 1.
        doReset("t2");
        for (int c = 0; c < 35; c++) begin
            applyStimulus((c == 0) ? 4'b0010 : 4'b0000, (c == 30) ? 4'b0010 : 4'b0000, 1'b1);
            expectLong(c, v, t);
            checkOutput($sformatf("t2 c%0d valid", c), 32'(evValid), 32'(v));
            if (v) begin
                checkOutput($sformatf("t2 c%0d type", c), 32'(evType), 32'(t));
                checkOutput($sformatf("t2 c%0d idx", c), 32'(evIdx), 32'd1);
            end
            checkOutput($sformatf("t2 c%0d drop", c), 32'(dropCnt), 32'd0);
            step();
        end

        // Simultaneous press of all buttons, then simultaneous release after rr wraps.
        doReset("t3");
        addVec(4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0);
        addIdle(1, 1'b1, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd1, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd2, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd3, 8'd0);
        addVec(4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0);
        addIdle(1, 1'b1, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd1, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd2, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd3, 8'd0);
        addIdle(1, 1'b1, 8'd0);
        runTable("t3");

        // Stalled consumer: FIFO fills, releases wait in slots, a PRESS on a busy slot is dropped.
        doReset("t4");
        addVec(4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0011, 1'b0, 1'b1, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 8'd0);
        addVec(4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd0, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd1, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd2, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd3, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd0, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd1, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd2, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd3, 8'd1);
        runTable("t4");

        // Blocked PRESS on button 3 is overwritten by its RELEASE.
        doReset("t5");
        addVec(4'b0111, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0001, 1'b0, 1'b1, 2'd0, 2'd0, 8'd0);
        addVec(4'b1000, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b1000, 1'b0, 1'b1, 2'd0, 2'd0, 8'd0);
        addVec(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd0, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd1, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd2, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd0, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd3, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd1, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd2, 8'd1);
        addVec(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 8'd1);
        runTable("t5");

        // Asynchronous reset while events are queued and button 0 is held.
        doReset("t6");
        applyStimulus(4'b0111, 4'b0000, 1'b0);
        step();
        applyStimulus(4'b0000, 4'b0010, 1'b0);
        step();
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        step();
        step();
        checkOutput("t6 pre-reset valid", 32'(evValid), 32'd1);
        checkOutput("t6 pre-reset drop", 32'(dropCnt), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6 async valid", 32'(evValid), 32'd0);
        checkOutput("t6 async drop", 32'(dropCnt), 32'd0);
        checkOutput("t6 async idx", 32'(evIdx), 32'd0);
        step();
        rst = 1'b0;
        applyStimulus(4'b0000, 4'b0001, 1'b1);
        step();
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("t6 post c%0d valid", c), 32'(evValid), 32'd0);
            checkOutput($sformatf("t6 post c%0d drop", c), 32'(dropCnt), 32'd0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
